core_mul_out: RTL and testbench
===============================

Name: core_mul_out

Overview:
Output-conditioning stage of the integer multiplier, the back end of the operand-conditioning path. It receives the unsigned 2*XLEN magnitude product from the multiplier array, plus the op control and the original operand sign bits. It restores the sign by two's-complement negation, selects the low half, high half or word result, and delivers a 2-stage pipelined, valid/ready-handshaked XLEN result to the EX writeback mux.

Parameters:
XLEN, 64, datapath width; product width is 2*XLEN; word width is XLEN/2.

Ports:
i_clk  input  1  core clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
i_mul_out_flush  input  1  synchronous pipeline kill (branch mispredict/trap)
i_mul_out_valid  input  1  upstream product valid
o_mul_out_ready  output  1  stage can accept a product this cycle
i_mul_out_product  input  2*XLEN  unsigned magnitude product |A|*|B|
i_mul_out_control  input  2  00 MUL/MULW, 01 MULH, 10 MULHSU, 11 MULHU
i_mul_out_isword  input  1  RV64 word op (MULW)
i_mul_out_srcA_sign  input  1  original sign of srcA: bit XLEN-1, or bit XLEN/2-1 when isword
i_mul_out_srcB_sign  input  1  original sign of srcB, same rule
o_mul_out_valid  output  1  result valid
i_mul_out_ready  input  1  downstream accepts result
o_mul_out_result  output  XLEN  signed-corrected result

Behaviour:
- Reset (async, i_rst_n=0): s1_valid=0, s2_valid=0, o_mul_out_valid=0, o_mul_out_result=0, all stage data regs 0. o_mul_out_ready=1 as soon as reset deasserts.
- Stage 1 (S1), capture on accept (i_mul_out_valid & o_mul_out_ready):
  - register product, control and isword
  - register neg flag:
    - !isword: MUL/MULH -> sA^sB; MULHSU -> sA; MULHU -> 0
    - isword & control==00 -> sA^sB
    - isword & control!=00 -> 0, and the op is treated as MULW with no negation
- Stage 2 (S2), output register, loaded from S1 on advance:
  - full = neg ? (~product + 1) : product, at 2*XLEN width; carry out is discarded
  - MUL -> full[XLEN-1:0]
  - MULH/MULHSU/MULHU -> full[2*XLEN-1:XLEN]
  - isword -> sign-extend full[XLEN/2-1:0] to XLEN
- Handshake:
  - s2_adv = s1_valid & (!s2_valid | i_mul_out_ready)
  - o_mul_out_ready = !s1_valid | s2_adv (combinational, no bubble when draining)
  - o_mul_out_valid = s2_valid; when i_mul_out_ready=1, s2_valid clears unless s2_adv reloads it
  - Latency: result valid exactly 2 cycles after the accept edge with no backpressure; throughput 1/cycle.
  - With i_mul_out_ready=0, o_mul_out_result and o_mul_out_valid hold stable; at most 2 ops are in flight; order is preserved.
- Flush: sets s1_valid=0 and s2_valid=0 next edge; data regs may keep stale values. Flush has priority over a same-cycle accept and over advance. An output handshaked in the flush cycle counts as delivered.
- Boundaries:
  - magnitude 0 with neg=1 yields 0
  - MULH of most-negative*most-negative: magnitude 2^(2*XLEN-2), neg=0, high = 2^(XLEN-2)
- Reset mid-operation drops all in-flight ops immediately.

Decomposition:
- Package core_mul_pkg: localparams MUL=2'b00, MULH=2'b01, MULHSU=2'b10, MULHU=2'b11, MULW=2'b00, and a typedef for the 2-bit mul control. This package is shared with the operand-conditioning stage.
- One sub-module core_mul_out_neg: combinational conditional two's-complement negate, parameterised width. It is instanced once at 2*XLEN in the S1->S2 path.

Test Plan:
- MUL -3*5: product=15, sA=1, sB=0, ctrl=00, ready=1 -> result 0xFFFF_FFFF_FFFF_FFF1, valid exactly 2 cycles after accept.
- MULH -1*1: product=1, sA=1, sB=0, ctrl=01 -> result 0xFFFF_FFFF_FFFF_FFFF. MULH -1*-1: product=1, sA=1, sB=1 -> result 0.
- MULHSU sA=1, sB=1, product=2^64 (high half 1), ctrl=10 -> neg on sA only -> result 0xFFFF_FFFF_FFFF_FFFF. Same operands as MULHU -> result 1.
- MULW 0x10000*0x8000: product=0x8000_0000, sA=sB=0, isword=1 -> result 0xFFFF_FFFF_8000_0000. isword=1 with ctrl=01 -> treated as MULW with no negation.
- Backpressure: 3 back-to-back ops, i_mul_out_ready=0 for 4 cycles -> o_mul_out_ready drops after 2 accepts, o_mul_out_result stable, all 3 delivered in order once ready=1.
- Flush with 2 in flight plus a same-cycle valid input -> no output valid afterwards and the input is not accepted. Async reset asserted mid-op -> o_mul_out_valid=0 and result=0 immediately.

Source files
------------

// File: rtl/core_mul_pkg.sv
// Shared multiplier control encodings, used by both the operand-conditioning
// stage and the output-conditioning stage.
package core_mul_pkg;

    typedef logic [1:0] mul_ctrl_t;

    localparam mul_ctrl_t MUL    = 2'b00;
    localparam mul_ctrl_t MULH   = 2'b01;
    localparam mul_ctrl_t MULHSU = 2'b10;
    localparam mul_ctrl_t MULHU  = 2'b11;
    localparam mul_ctrl_t MULW   = 2'b00;

endpackage

// File: rtl/core_mul_out_neg.sv
// Conditional two's-complement negate; the carry out of the increment is dropped.
module core_mul_out_neg #(
    parameter int W = 128
) (
    input  logic         i_neg,
    input  logic [W-1:0] i_val,
    output logic [W-1:0] o_val
);

    always_comb begin
        o_val = i_val;
        if (i_neg) begin
            o_val = ~i_val + {{(W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/core_mul_out.sv
// Multiplier output conditioning: restores the product sign, selects the
// low/high/word result and delivers it through a 2-stage valid/ready pipeline.
module core_mul_out
    import core_mul_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_mul_out_flush,
    input  logic              i_mul_out_valid,
    output logic              o_mul_out_ready,
    input  logic [2*XLEN-1:0] i_mul_out_product,
    input  logic [1:0]        i_mul_out_control,
    input  logic              i_mul_out_isword,
    input  logic              i_mul_out_srcA_sign,
    input  logic              i_mul_out_srcB_sign,
    output logic              o_mul_out_valid,
    input  logic              i_mul_out_ready,
    output logic [XLEN-1:0]   o_mul_out_result
);

    localparam int PW = 2 * XLEN;
    localparam int HW = XLEN / 2;

    logic              s1_valid_q,   s1_valid_d;
    logic [PW-1:0]     s1_product_q, s1_product_d;
    mul_ctrl_t         s1_ctrl_q,    s1_ctrl_d;
    logic              s1_isword_q,  s1_isword_d;
    logic              s1_neg_q,     s1_neg_d;
    logic              s2_valid_q,   s2_valid_d;
    logic [XLEN-1:0]   s2_result_q,  s2_result_d;

    logic              s2_adv;
    logic              accept;
    logic              neg_in;
    logic [PW-1:0]     full;
    logic [XLEN-1:0]   sel_result;

    assign s2_adv          = s1_valid_q & (~s2_valid_q | i_mul_out_ready);
    assign o_mul_out_ready = ~s1_valid_q | s2_adv;
    // A flush wins over an accept presented in the same cycle.
    assign accept          = i_mul_out_valid & o_mul_out_ready & ~i_mul_out_flush;

    // Word ops with a non-MULW control collapse to plain MULW without negation.
    always_comb begin
        neg_in = 1'b0;
        if (i_mul_out_isword) begin
            if (mul_ctrl_t'(i_mul_out_control) == MULW) begin
                neg_in = i_mul_out_srcA_sign ^ i_mul_out_srcB_sign;
            end
        end else begin
            case (mul_ctrl_t'(i_mul_out_control))
                MUL, MULH: neg_in = i_mul_out_srcA_sign ^ i_mul_out_srcB_sign;
                MULHSU:    neg_in = i_mul_out_srcA_sign;
                default:   neg_in = 1'b0;
            endcase
        end
    end

    core_mul_out_neg #(
        .W (PW)
    ) u_neg (
        .i_neg (s1_neg_q),
        .i_val (s1_product_q),
        .o_val (full)
    );

    always_comb begin
        if (s1_isword_q) begin
            sel_result = {{(XLEN-HW){full[HW-1]}}, full[HW-1:0]};
        end else if (s1_ctrl_q == MUL) begin
            sel_result = full[XLEN-1:0];
        end else begin
            sel_result = full[PW-1:XLEN];
        end
    end

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_product_d = s1_product_q;
        s1_ctrl_d    = s1_ctrl_q;
        s1_isword_d  = s1_isword_q;
        s1_neg_d     = s1_neg_q;
        s2_valid_d   = s2_valid_q;
        s2_result_d  = s2_result_q;

        if (i_mul_out_flush) begin
            s1_valid_d = 1'b0;
        end else if (accept) begin
            s1_valid_d = 1'b1;
        end else if (s2_adv) begin
            s1_valid_d = 1'b0;
        end

        if (accept) begin
            s1_product_d = i_mul_out_product;
            s1_ctrl_d    = mul_ctrl_t'(i_mul_out_control);
            s1_isword_d  = i_mul_out_isword;
            s1_neg_d     = neg_in;
        end

        if (i_mul_out_flush) begin
            s2_valid_d = 1'b0;
        end else if (s2_adv) begin
            s2_valid_d = 1'b1;
        end else if (i_mul_out_ready) begin
            s2_valid_d = 1'b0;
        end

        if (s2_adv && !i_mul_out_flush) begin
            s2_result_d = sel_result;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_product_q <= '0;
            s1_ctrl_q    <= MUL;
            s1_isword_q  <= 1'b0;
            s1_neg_q     <= 1'b0;
            s2_valid_q   <= 1'b0;
            s2_result_q  <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_product_q <= s1_product_d;
            s1_ctrl_q    <= s1_ctrl_d;
            s1_isword_q  <= s1_isword_d;
            s1_neg_q     <= s1_neg_d;
            s2_valid_q   <= s2_valid_d;
            s2_result_q  <= s2_result_d;
        end
    end

    assign o_mul_out_valid  = s2_valid_q;
    assign o_mul_out_result = s2_result_q;

endmodule

// File: tb/tb_core_mul_out.sv
// Directed bench for core_mul_out: vector table plus backpressure, flush and
// asynchronous reset sequences.
module tb_core_mul_out;

    localparam int XLEN = 64;

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [2*XLEN-1:0] product;
    logic [1:0]        ctrl;
    logic              isword;
    logic              sa;
    logic              sb;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   result;

    int pass_cnt;
    int total_cnt;

    core_mul_out #(.XLEN(XLEN)) dut (
        .i_clk               (clk),
        .i_rst_n             (rst_n),
        .i_mul_out_flush     (flush),
        .i_mul_out_valid     (in_valid),
        .o_mul_out_ready     (in_ready),
        .i_mul_out_product   (product),
        .i_mul_out_control   (ctrl),
        .i_mul_out_isword    (isword),
        .i_mul_out_srcA_sign (sa),
        .i_mul_out_srcB_sign (sb),
        .o_mul_out_valid     (out_valid),
        .i_mul_out_ready     (out_ready),
        .o_mul_out_result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string             name;
        logic [2*XLEN-1:0] product;
        logic [1:0]        ctrl;
        logic              isword;
        logic              sa;
        logic              sb;
        logic [XLEN-1:0]   exp;
    } vec_t;

    vec_t vecs[12];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2*XLEN-1:0] p, input logic [1:0] c, input logic w,
                         input logic a, input logic b);
        product  = p;
        ctrl     = c;
        isword   = w;
        sa       = a;
        sb       = b;
        in_valid = 1'b1;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        product   = '0;
        ctrl      = 2'b00;
        isword    = 1'b0;
        sa        = 1'b0;
        sb        = 1'b0;

        vecs[0]  = '{"mul_neg3x5",      {64'h0, 64'd15},                  2'b00, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF1};
        vecs[1]  = '{"mulh_m1x1",       {64'h0, 64'd1},                   2'b01, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[2]  = '{"mulh_m1xm1",      {64'h0, 64'd1},                   2'b01, 1'b0, 1'b1, 1'b1, 64'h0};
        vecs[3]  = '{"mulhsu_neg",      {64'h1, 64'h0},                   2'b10, 1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[4]  = '{"mulhu_same",      {64'h1, 64'h0},                   2'b11, 1'b0, 1'b1, 1'b1, 64'h1};
        vecs[5]  = '{"mulw_sext",       {64'h0, 64'h8000_0000},           2'b00, 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_8000_0000};
        vecs[6]  = '{"word_ctrl01_noneg", {64'h0, 64'd5},                 2'b01, 1'b1, 1'b1, 1'b0, 64'h5};
        vecs[7]  = '{"mul_zero_neg",    {64'h0, 64'h0},                   2'b00, 1'b0, 1'b1, 1'b0, 64'h0};
        vecs[8]  = '{"mulh_mostneg",    {64'h4000_0000_0000_0000, 64'h0}, 2'b01, 1'b0, 1'b1, 1'b1, 64'h4000_0000_0000_0000};
        vecs[9]  = '{"mul_low_only",    {64'h1, 64'h8000_0000_0000_0000}, 2'b00, 1'b0, 1'b0, 1'b0, 64'h8000_0000_0000_0000};
        vecs[10] = '{"mulw_neg3",       {64'h0, 64'd3},                   2'b00, 1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD};
        vecs[11] = '{"mulhsu_sb_ignored", {64'h5, 64'h0},                 2'b10, 1'b0, 1'b0, 1'b1, 64'h5};

        step();
        step();
        check("reset_valid", {63'h0, out_valid}, 64'h0);
        check("reset_result", result, 64'h0);
        rst_n = 1'b1;
        #1;
        check("reset_ready", {63'h0, in_ready}, 64'h1);

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].product, vecs[i].ctrl, vecs[i].isword, vecs[i].sa, vecs[i].sb);
            step();
            in_valid = 1'b0;
            check({vecs[i].name, "_lat1"}, {63'h0, out_valid}, 64'h0);
            step();
            check({vecs[i].name, "_valid"}, {63'h0, out_valid}, 64'h1);
            check(vecs[i].name, result, vecs[i].exp);
        end
        step();
        check("drain_idle", {63'h0, out_valid}, 64'h0);

        // Backpressure: three back-to-back ops with downstream stalled.
        out_ready = 1'b0;
        drive({64'h0, 64'd1}, 2'b00, 1'b0, 1'b0, 1'b0);
        check("bp_ready_a", {63'h0, in_ready}, 64'h1);
        step();
        drive({64'h0, 64'd2}, 2'b00, 1'b0, 1'b0, 1'b0);
        check("bp_ready_b", {63'h0, in_ready}, 64'h1);
        step();
        drive({64'h0, 64'd3}, 2'b00, 1'b0, 1'b0, 1'b0);
        check("bp_ready_drop", {63'h0, in_ready}, 64'h0);
        for (int k = 0; k < 4; k++) begin
            check("bp_hold_valid", {63'h0, out_valid}, 64'h1);
            check("bp_hold_result", result, 64'd1);
            check("bp_hold_ready", {63'h0, in_ready}, 64'h0);
            step();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", {63'h0, in_ready}, 64'h1);
        check("bp_out_a", result, 64'd1);
        step();
        in_valid = 1'b0;
        check("bp_out_b_valid", {63'h0, out_valid}, 64'h1);
        check("bp_out_b", result, 64'd2);
        step();
        check("bp_out_c_valid", {63'h0, out_valid}, 64'h1);
        check("bp_out_c", result, 64'd3);
        step();
        check("bp_empty", {63'h0, out_valid}, 64'h0);

        // Flush with two ops in flight and a new op presented the same cycle.
        out_ready = 1'b0;
        drive({64'h0, 64'd7}, 2'b00, 1'b0, 1'b0, 1'b0);
        step();
        drive({64'h0, 64'd8}, 2'b00, 1'b0, 1'b0, 1'b0);
        step();
        drive({64'h0, 64'd9}, 2'b00, 1'b0, 1'b0, 1'b0);
        check("fl_pre_valid", {63'h0, out_valid}, 64'h1);
        flush = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("fl_valid0", {63'h0, out_valid}, 64'h0);
        check("fl_ready", {63'h0, in_ready}, 64'h1);
        step();
        check("fl_valid1", {63'h0, out_valid}, 64'h0);
        step();
        check("fl_valid2", {63'h0, out_valid}, 64'h0);

        // Asynchronous reset while an op sits in the output register.
        drive({64'h0, 64'd15}, 2'b00, 1'b0, 1'b1, 1'b0);
        step();
        in_valid = 1'b0;
        out_ready = 1'b0;
        step();
        check("ar_pre_valid", {63'h0, out_valid}, 64'h1);
        check("ar_pre_result", result, 64'hFFFF_FFFF_FFFF_FFF1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid", {63'h0, out_valid}, 64'h0);
        check("ar_result", result, 64'h0);
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        check("ar_ready", {63'h0, in_ready}, 64'h1);
        step();
        check("ar_stays_idle", {63'h0, out_valid}, 64'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
